// File: rtl/div_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states, handshake levels
// and the zero word used to clear results.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam int          DIV_DEFAULT_WIDTH = 32;
    localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;

endpackage

// File: rtl/div.sv
// Restoring signed/unsigned divider, one quotient bit per cycle; ready 33 edges after accept (1 for /0).
// Holds the result while start_i stays high; annul_i aborts a running divide; no input backpressure.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int              CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    div_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH:0]       work_q, work_d;
    logic [WIDTH-1:0]       divisor_q, divisor_d;
    logic                   neg_quot_q, neg_quot_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic                   ready_q, ready_d;

    logic [WIDTH-1:0]       op1_abs;
    logic [WIDTH-1:0]       op2_abs;
    logic [WIDTH:0]         diff;
    logic [WIDTH-1:0]       quot;
    logic [WIDTH-1:0]       rem;

    // Magnitudes are only taken in signed mode; unsigned operands pass through.
    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + ONE) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + ONE) : opdata2_i;
    assign diff    = {1'b0, work_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        quot       = work_q[WIDTH-1:0];
        rem        = work_q[2*WIDTH:WIDTH+1];

        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = '0;
                        // Dividend is pre-shifted by one so each step compares the next bit.
                        work_d     = {{WIDTH{1'b0}}, op1_abs, 1'b0};
                        divisor_d  = op2_abs;
                        neg_quot_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
            end

            DIV_BY_ZERO: begin
                state_d  = DIV_END;
                result_d = '0;
                ready_d  = DIV_RESULT_READY;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                    cnt_d   = '0;
                    work_d  = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    if (neg_quot_q) begin
                        quot = ~work_q[WIDTH-1:0] + ONE;
                    end
                    if (neg_rem_q) begin
                        rem = ~work_q[2*WIDTH:WIDTH+1] + ONE;
                    end
                    result_d = {rem, quot};
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                    cnt_d    = '0;
                end else begin
                    if (diff[WIDTH]) begin
                        work_d = {work_q[2*WIDTH-1:0], 1'b0};
                    end else begin
                        work_d = {diff[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = DIV_FREE;
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Bench for div: arithmetic reference model plus cycle-by-cycle output compare,
// with directed vectors carrying hand-computed results and latencies.
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    div #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference quotient/remainder straight from integer arithmetic.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Timing model: idle -> busy (33 edges, or 1 for /0) -> done while start held.
    bit          m_busy, m_done, m_zero;
    int          m_left;
    logic [63:0] m_res;
    logic        exp_ready;
    logic [63:0] exp_result;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_zero = 1'b0; m_left = 0;
            exp_ready = 1'b0; exp_result = '0;
        end else if (m_done) begin
            if (!start_i) begin
                m_done = 1'b0; exp_ready = 1'b0; exp_result = '0;
            end
        end else if (m_busy) begin
            if (annul_i && !m_zero) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    exp_ready = 1'b1; exp_result = m_res;
                end
            end
        end else if (start_i && !annul_i) begin
            m_busy = 1'b1;
            m_zero = (opdata2_i == 32'd0);
            m_left = m_zero ? 1 : 33;
            m_res  = ref_div(signed_div_i, opdata1_i, opdata2_i);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_ready", {63'd0, ready_o}, {63'd0, exp_ready});
            chk("cyc_result", result_o, exp_result);
        end
    end

    task automatic run_op(input string name, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        int k;
        @(negedge clk);
        signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
            end
            if (ready_o) break;
        end
        chk({name, "_latency"}, 64'(k - 1), 64'(exp_lat));
        chk({name, "_result"}, result_o, exp_res);
        @(negedge clk);
        @(negedge clk);
        chk({name, "_hold"}, result_o, exp_res);
        start_i = 1'b0;
        @(negedge clk);
        chk({name, "_idle"}, {63'd0, ready_o}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int k;
        #1;
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);

        chk("model_100_7", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model_m7_2", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model_min_m1", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});

        repeat (2) @(negedge clk);
        rst = 1'b1;
        cmp_en = 1'b1;

        run_op("u100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}, 33);
        run_op("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_op("s_7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD}, 33);
        run_op("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF}, 33);
        run_op("s_m1_1",   1'b1, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF}, 33);
        run_op("s_min_m1", 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000}, 33);
        run_op("u_div0",   1'b0, 32'd5,          32'd0,          64'd0, 1);
        run_op("s_div0",   1'b1, 32'hFFFF_FFFB,  32'd0,          64'd0, 1);
        run_op("u_max_16", 1'b0, 32'hFFFF_FFFF,  32'd16,         {32'd15, 32'h0FFF_FFFF}, 33);
        run_op("s_m100_m7",1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14}, 33);
        run_op("u_3_10",   1'b0, 32'd3,          32'd10,         {32'd3, 32'd0}, 33);

        // Abort ten cycles into a divide: no result may ever appear.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (11) @(negedge clk);
        start_i = 1'b0; annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) bad++;
        end
        chk("annul_no_ready", 64'(bad), 64'd0);
        run_op("after_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        // Reset asserted between edges while the divide is running.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b0; start_i = 1'b0;
        #1;
        chk("rst_on_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_on_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("after_rst_on", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        // Reset asserted while a finished result is being shown.
        @(negedge clk);
        signed_div_i = 1'b1; opdata1_i = 32'hFFFF_FFF9; opdata2_i = 32'd2; start_i = 1'b1;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (ready_o) break;
        end
        chk("end_before_rst", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        #2;
        rst = 1'b0; start_i = 1'b0;
        #1;
        chk("rst_end_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_end_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("after_rst_end", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
